// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: drives trial values onto a comparator, resolves the target MSB first.
// Latency: done in cycle T+1+n for n comparisons; stalls on cmp_valid=0 for any number of cycles without losing state.
module sar_search_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] guess,
   output logic             cmp_req,
   input  logic             cmp_valid,
   input  logic             a_greater_b,
   input  logic             a_equal_b,
   input  logic             a_lesser_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             err
);

   localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [KW-1:0]    k_q, k_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] bit_mask, trial, acc_upd;
   logic             consume, flags_onehot;

   assign bit_mask     = WIDTH'(1) << k_q;
   assign trial        = acc_q | bit_mask;
   assign acc_upd      = a_greater_b ? trial : acc_q;
   assign flags_onehot = $onehot({a_greater_b, a_equal_b, a_lesser_b});

   assign cmp_req = (state_q == SEARCH);
   assign guess   = cmp_req ? trial : '0;
   assign busy    = (state_q != IDLE);
   assign done    = (state_q == FINISH);
   assign result  = result_q;
   assign err     = err_q;
   assign consume = cmp_req & cmp_valid;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      k_d      = k_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SEARCH;
               acc_d    = '0;
               k_d      = KW'(WIDTH - 1);
               result_d = '0;
               err_d    = 1'b0;
            end
         end
         SEARCH: begin
            if (consume) begin
               // Malformed flags end the search with whatever bits were already resolved.
               if (!flags_onehot) begin
                  state_d  = FINISH;
                  err_d    = 1'b1;
                  result_d = acc_q;
               end else if (a_equal_b) begin
                  state_d  = FINISH;
                  result_d = trial;
               end else if (k_q == '0) begin
                  state_d  = FINISH;
                  acc_d    = acc_upd;
                  result_d = acc_upd;
               end else begin
                  acc_d = acc_upd;
                  k_d   = k_q - KW'(1);
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         k_q      <= KW'(WIDTH - 1);
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         k_q      <= k_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Bench for sar_search_ctrl: directed vector table, hand sequences for reset abort, random targets vs a reference model.
module tb_sar_search_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] guess;
   logic       cmp_req;
   logic       cmp_valid = 1'b1;
   logic       a_greater_b, a_equal_b, a_lesser_b;
   logic       busy, done, err;
   logic [7:0] result;

   logic [7:0] target = 8'h00;
   logic       inj = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Comparator model; inj forces an illegal greater+lesser response.
   always_comb begin
      a_greater_b = inj ? 1'b1 : (target > guess);
      a_lesser_b  = inj ? 1'b1 : (target < guess);
      a_equal_b   = inj ? 1'b0 : (target == guess);
   end

   sar_search_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .guess(guess), .cmp_req(cmp_req),
      .cmp_valid(cmp_valid), .a_greater_b(a_greater_b), .a_equal_b(a_equal_b),
      .a_lesser_b(a_lesser_b), .busy(busy), .done(done), .result(result), .err(err)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Number of comparisons: search stops at the lowest set bit of the target, or runs all 8 for zero.
   function automatic int model_n(input logic [7:0] tgt);
      int tz;
      if (tgt == 8'h00) return 8;
      tz = 0;
      while (((tgt >> tz) & 8'h01) == 8'h00) tz++;
      return 8 - tz;
   endfunction

   // i-th trial value: target's bits above position k kept, bit k set, lower bits clear.
   function automatic int model_guess(input logic [7:0] tgt, input int i);
      int k;
      k = 7 - i;
      return (int'(tgt) & ~((1 << (k + 1)) - 1)) | (1 << k);
   endfunction

   task automatic run_search(input logic [7:0] tgt, input int stall_at, input int stall_len,
                             input int err_at, input int start_at,
                             output int cyc, output logic [7:0] res, output logic e);
      int resp, stalled;
      logic seen_done;
      resp = 0; stalled = 0; cyc = 0; seen_done = 1'b0; res = 8'h00; e = 1'b0;
      @(negedge clk);
      target = tgt; inj = 1'b0; cmp_valid = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (!seen_done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         start = (cyc == start_at);
         inj = 1'b0;
         if (cyc == 1) begin
            chk("result_cleared_on_start", result, 0);
            chk("err_cleared_on_start", err, 0);
         end
         if (done) begin
            seen_done = 1'b1;
            chk("busy_in_finish", busy, 1);
            chk("cmp_req_in_finish", cmp_req, 0);
            res = result;
            e = err;
         end else begin
            chk("cmp_req_in_search", cmp_req, 1);
            chk("busy_in_search", busy, 1);
            chk("guess", guess, model_guess(tgt, resp));
            if (resp == stall_at && stalled < stall_len) begin
               cmp_valid = 1'b0;
               stalled++;
            end else begin
               cmp_valid = 1'b1;
               inj = (resp == err_at);
               resp++;
            end
         end
      end
      start = 1'b0; inj = 1'b0; cmp_valid = 1'b1;
      if (!seen_done) chk("done_timeout", 0, 1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("done_after_finish", done, 0);
         chk("busy_after_finish", busy, 0);
         chk("guess_idle", guess, 0);
      end
   endtask

   typedef struct {
      logic [7:0] tgt;
      int         stall_at;
      int         stall_len;
      int         err_at;
      int         start_at;
      logic [7:0] exp_res;
      logic       exp_err;
      int         exp_cyc;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int cyc, n, sa, sl;
      logic [7:0] res, tgt;
      logic e;

      vecs[0] = '{8'h5A, -1, 0, -1, -1, 8'h5A, 1'b0, 8};
      vecs[1] = '{8'h00, -1, 0, -1, -1, 8'h00, 1'b0, 9};
      vecs[2] = '{8'hFF, -1, 0, -1, -1, 8'hFF, 1'b0, 9};
      vecs[3] = '{8'h80, -1, 0, -1, -1, 8'h80, 1'b0, 2};
      vecs[4] = '{8'h5A,  1, 3, -1, -1, 8'h5A, 1'b0, 11};
      vecs[5] = '{8'h5A, -1, 0,  2, -1, 8'h40, 1'b1, 4};
      vecs[6] = '{8'h5A, -1, 0, -1,  3, 8'h5A, 1'b0, 8};

      #12;
      chk("rst_busy", busy, 0);
      chk("rst_cmp_req", cmp_req, 0);
      chk("rst_done", done, 0);
      chk("rst_guess", guess, 0);
      chk("rst_result", result, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         run_search(vecs[i].tgt, vecs[i].stall_at, vecs[i].stall_len, vecs[i].err_at,
                    vecs[i].start_at, cyc, res, e);
         chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cyc);
         chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
         chk($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
         chk($sformatf("vec%0d_result_held", i), result, vecs[i].exp_res);
         chk($sformatf("vec%0d_err_held", i), err, vecs[i].exp_err);
      end

      // Reset in the middle of a search: outputs drop without waiting for a clock edge.
      @(negedge clk);
      target = 8'h5A; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_cmp_req", cmp_req, 0);
      chk("abort_guess", guess, 0);
      chk("abort_result", result, 0);
      chk("abort_err", err, 0);
      chk("abort_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_no_resume", busy, 0);
      run_search(8'h5A, -1, 0, -1, -1, cyc, res, e);
      chk("post_abort_cycles", cyc, 8);
      chk("post_abort_result", res, 8'h5A);
      chk("post_abort_err", e, 0);

      for (int r = 0; r < 20; r++) begin
         tgt = 8'($urandom);
         n = model_n(tgt);
         sa = $urandom_range(0, n - 1);
         sl = $urandom_range(0, 3);
         run_search(tgt, sa, sl, -1, -1, cyc, res, e);
         chk($sformatf("rand%0d_cycles", r), cyc, 1 + n + sl);
         chk($sformatf("rand%0d_result", r), res, tgt);
         chk($sformatf("rand%0d_err", r), e, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sar_search_ctrl.md
Name: sar_search_ctrl

Overview:
- Successive-approximation search controller, acting as initiator to a magnitude comparator. It drives trial values onto the comparator's b operand and reads back greater/equal/lesser flags.
- It resolves an unknown value held on the comparator's a operand, MSB first.
- It is the driving end of the comparator interface: it sequences guesses rather than comparing fixed operands.
- Used for ADC-style threshold search and lookup of externally held values.

Parameters:
WIDTH, 8, operand width in bits; search takes at most WIDTH comparisons.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a new search; sampled only in IDLE
guess  output  WIDTH  trial value driven to comparator b operand
cmp_req  output  1  guess is valid, comparator response requested
cmp_valid  input  1  comparator flags valid for current guess
a_greater_b  input  1  target > guess
a_equal_b  input  1  target == guess
a_lesser_b  input  1  target < guess
busy  output  1  search in progress
done  output  1  one-cycle pulse: search finished
result  output  WIDTH  found value; held until next start accepted
err  output  1  flags were not one-hot at a consumed response; held with result

Behaviour:
- Reset (async assert, sync release): state=IDLE; guess=0, cmp_req=0, busy=0, done=0, result=0, err=0; internal acc=0, bit index=WIDTH-1.
- States:
  - IDLE -> SEARCH on start=1.
  - SEARCH -> FINISH on terminal response.
  - FINISH -> IDLE unconditionally after 1 cycle.
- Start accept:
  - Edge T with start=1 in IDLE clears acc, result and err.
  - In cycle T+1: busy=1, cmp_req=1, guess = 1<<(WIDTH-1).
- SEARCH:
  - guess = acc | (1<<k) for current bit k; cmp_req=1.
  - A response is consumed on an edge where cmp_req=1 and cmp_valid=1.
  - While cmp_valid=0, guess, k and acc hold (stall of any length).
- On a consumed response:
  - Flags not exactly one-hot: terminal; err=1, result=acc.
  - a_equal_b: terminal; result=guess (early exit).
  - a_greater_b: acc |= 1<<k.
  - a_lesser_b: acc unchanged.
  - k==0 with greater or lesser: terminal; result = acc after update.
  - Otherwise k decrements and the new guess appears the next cycle. Back-to-back consumption is allowed, so with cmp_valid tied high there is one comparison per cycle.
- Terminal edge E:
  - Cycle E+1: state FINISH, done=1, busy=1, cmp_req=0, result/err valid.
  - Cycle E+2: IDLE, busy=0, done=0, guess=0.
  - result/err persist until the next start is accepted.
- Latency:
  - With cmp_valid always 1 and a search of n comparisons, done is high in cycle T+1+n.
  - n ≤ WIDTH.
- Ignored inputs:
  - start while busy (SEARCH/FINISH) is ignored and not queued.
  - cmp_valid outside SEARCH is ignored.
- Reset mid-search: all outputs return to reset values immediately. There is no done pulse and the aborted search does not resume.

Test Plan:
Bench uses WIDTH=8, a combinational comparator model with a=target and b=guess, and cmp_valid=1 unless stated.
- Target 0x5A: guesses 0x80,0x40,0x60,0x50,0x58,0x5C,0x5A -> equal at 7th response; done at T+8, result=0x5A, err=0.
- Target 0x00: guesses 0x80,0x40,0x20,...,0x01 all lesser -> done at T+9, result=0x00. Target 0xFF: guesses 0x80,0xC0,...,0xFE,0xFF -> equal on 8th, result=0xFF. Target 0x80: equal on first guess -> done at T+2, result=0x80.
- Stall: target 0x5A, cmp_valid low for 3 cycles after the 2nd guess -> guess holds 0x40, cmp_req stays 1; result 0x5A, done delayed exactly 3 cycles.
- Protocol error: on 3rd response force a_greater_b=a_lesser_b=1 -> done pulse, err=1, result=acc (0x40 for target 0x5A).
- start pulsed during SEARCH -> ignored, single done pulse. Assert rst_n=0 mid-search -> busy, cmp_req, guess, result, err all 0 asynchronously; new start afterwards completes normally.
